compute_array_sched: RTL and testbench

//  Job sequencer for the MAC compute array; owns no datapath.
//  - Accepts a reduction job: depth K, precision mode, act/wgt base addresses.
//  - Issues K operand-buffer reads and holds the array ctrl mode for the whole job.
//  - Steers the acc input: zero on the first step, partial-sum feedback afterwards.
//  - Strobes the external psum register, then presents the result under a valid/ready handshake.

---
 rtl/compute_array_sched.sv | 162 ++++++++++++++++
 tb/tb_compute_array_sched.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/compute_array_sched.sv
// ---------------------------------------------------------------------------
// compute_array_sched
//   Job sequencer for the MAC compute array. It owns no datapath. It accepts
//   a reduction job, issues K operand-buffer reads, and holds the array
//   control mode for the whole job. It steers the accumulator input: zero on
//   the first step, and partial-sum feedback after that. It strobes the
//   external psum register, then presents the result under valid/ready.
//
//   Optional feature macro: PERF_CNT_EN (adds perf_busy_cyc / perf_stall_cyc).
//
// Ports
//   clk, reset          clock; asynchronous active-low reset
//   cmd_valid/ready     job request / accept (ready only in IDLE)
//   cmd_k               reduction depth (0 behaves as 1)
//   cmd_mode            precision mode, forwarded to arr_ctrl
//   cmd_act/wgt_base    first activation / weight addresses
//   buf_rd_en           operand read strobe (data returns one cycle later)
//   act_addr, wgt_addr  operand read addresses (wrap modulo 2**ADDR_W)
//   arr_ctrl            array mode, stable for the whole job
//   acc_sel             0: acc = 0, 1: acc = psum feedback
//   psum_we             capture the array output into the psum register
//   res_valid/ready     result handshake
//   busy                any state other than IDLE
//   done_pulse          one cycle after the result handshake
//   perf_busy_cyc       (PERF_CNT_EN) saturating count of busy cycles
//   perf_stall_cyc      (PERF_CNT_EN) saturating count of res_valid&~res_ready
// ---------------------------------------------------------------------------
module compute_array_sched #(
    parameter int ADDR_W  = 10,
    parameter int KCNT_W  = 8,
    parameter int ARR_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [KCNT_W-1:0] cmd_k,
    input  logic [1:0]        cmd_mode,
    input  logic [ADDR_W-1:0] cmd_act_base,
    input  logic [ADDR_W-1:0] cmd_wgt_base,
    output logic              buf_rd_en,
    output logic [ADDR_W-1:0] act_addr,
    output logic [ADDR_W-1:0] wgt_addr,
    output logic [1:0]        arr_ctrl,
    output logic              acc_sel,
    output logic              psum_we,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              busy,
`ifdef PERF_CNT_EN
    output logic [31:0]       perf_busy_cyc,
    output logic [31:0]       perf_stall_cyc,
`endif
    output logic              done_pulse
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_OUT   = 2'd3;

    // The wait counter runs 0..ARR_LAT and is always at least one bit wide.
    localparam int              WC_W      = (ARR_LAT < 1) ? 1 : $clog2(ARR_LAT + 1);
    localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(ARR_LAT);

    logic [1:0]        state;
    logic              armed;
    logic [KCNT_W-1:0] step;
    logic [KCNT_W-1:0] k_q;
    logic [WC_W-1:0]   wait_cnt;
    logic [ADDR_W-1:0] act_base_q;
    logic [ADDR_W-1:0] wgt_base_q;

    logic last_wait;
    logic last_step;

    assign last_wait = (state == S_WAIT) && (wait_cnt == WAIT_LAST);
    // k_q is never 0, so k_q-1 cannot underflow. step never passes k_q-1, so
    // the largest depth (2**KCNT_W-1) fits in the counter.
    assign last_step = (step == k_q - KCNT_W'(1));

    // NOTE: 'armed' keeps cmd_ready low while reset is held and for the first
    // edge after release. A plain decode of state==IDLE would raise
    // cmd_ready during reset.
    assign cmd_ready = armed && (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign buf_rd_en = (state == S_ISSUE);
    assign act_addr  = buf_rd_en ? act_base_q + ADDR_W'(step) : '0;
    assign wgt_addr  = buf_rd_en ? wgt_base_q + ADDR_W'(step) : '0;
    assign acc_sel   = (state == S_WAIT) && (step != '0);
    assign psum_we   = last_wait;
    assign res_valid = (state == S_OUT);

    // NOTE: all sequential state uses non-blocking assignments. Every
    // register here sees the pre-edge values of its peers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            armed      <= 1'b0;
            step       <= '0;
            k_q        <= '0;
            wait_cnt   <= '0;
            act_base_q <= '0;
            wgt_base_q <= '0;
            arr_ctrl   <= 2'b00;
            done_pulse <= 1'b0;
        end else begin
            armed      <= 1'b1;
            done_pulse <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_valid && armed) begin
                        k_q        <= (cmd_k == '0) ? KCNT_W'(1) : cmd_k;
                        arr_ctrl   <= cmd_mode;
                        act_base_q <= cmd_act_base;
                        wgt_base_q <= cmd_wgt_base;
                        step       <= '0;
                        state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    wait_cnt <= '0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        if (last_step) begin
                            state <= S_OUT;
                        end else begin
                            step  <= step + KCNT_W'(1);
                            state <= S_ISSUE;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + WC_W'(1);
                    end
                end
                S_OUT: begin
                    if (res_ready) begin
                        state      <= S_IDLE;
                        done_pulse <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef PERF_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_busy_cyc  <= '0;
            perf_stall_cyc <= '0;
        end else begin
            if (busy && (perf_busy_cyc != '1))
                perf_busy_cyc <= perf_busy_cyc + 32'd1;
            if (res_valid && !res_ready && (perf_stall_cyc != '1))
                perf_stall_cyc <= perf_stall_cyc + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_compute_array_sched.sv
// ---------------------------------------------------------------------------
// tb_compute_array_sched
//   Directed testbench for compute_array_sched (ARR_LAT=1, ADDR_W=10,
//   KCNT_W=8). Inputs change and outputs are sampled on the falling clock
//   edge. The DUT registers on the rising edge.
// ---------------------------------------------------------------------------
module tb_compute_array_sched;

    logic       clk;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_k;
    logic [1:0] cmd_mode;
    logic [9:0] cmd_act_base;
    logic [9:0] cmd_wgt_base;
    logic       buf_rd_en;
    logic [9:0] act_addr;
    logic [9:0] wgt_addr;
    logic [1:0] arr_ctrl;
    logic       acc_sel;
    logic       psum_we;
    logic       res_valid;
    logic       res_ready;
    logic       busy;
    logic       done_pulse;
`ifdef PERF_CNT_EN
    logic [31:0] perf_busy_cyc;
    logic [31:0] perf_stall_cyc;
`endif

    int passed = 0;
    int total  = 0;

    logic [9:0] rec_act [256];
    logic [9:0] rec_wgt [256];

    compute_array_sched #(.ADDR_W(10), .KCNT_W(8), .ARR_LAT(1)) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_k        (cmd_k),
        .cmd_mode     (cmd_mode),
        .cmd_act_base (cmd_act_base),
        .cmd_wgt_base (cmd_wgt_base),
        .buf_rd_en    (buf_rd_en),
        .act_addr     (act_addr),
        .wgt_addr     (wgt_addr),
        .arr_ctrl     (arr_ctrl),
        .acc_sel      (acc_sel),
        .psum_we      (psum_we),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .busy         (busy),
`ifdef PERF_CNT_EN
        .perf_busy_cyc  (perf_busy_cyc),
        .perf_stall_cyc (perf_stall_cyc),
`endif
        .done_pulse   (done_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Runs one job from accept to the done pulse. Each cycle is compared
    // against a step/phase timeline: ISSUE, WAIT, WAIT(psum_we) per step,
    // then OUT. Output vector order:
    // {buf_rd_en, acc_sel, psum_we, res_valid, busy, cmd_ready, done_pulse}.
    task automatic run_job(input logic [7:0] k, input logic [1:0] mode,
                           input logic [9:0] ab, input logic [9:0] wb,
                           input int stall);
        int         kk;
        int         len;
        int         waited;
        logic [6:0] exp_v;
        logic [6:0] got_v;
`ifdef PERF_CNT_EN
        logic [31:0] busy0;
        logic [31:0] stall0;
`endif
        kk  = (k == 8'd0) ? 1 : int'(k);
        len = kk * 3;
        waited = 0;
        while (cmd_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        total++;
        if (cmd_ready === 1'b1) passed++;
        else $display("FAIL job_ready_timeout: cmd_ready=%b expected 1", cmd_ready);
`ifdef PERF_CNT_EN
        busy0  = perf_busy_cyc;
        stall0 = perf_stall_cyc;
`endif
        cmd_valid    = 1'b1;
        cmd_k        = k;
        cmd_mode     = mode;
        cmd_act_base = ab;
        cmd_wgt_base = wb;
        res_ready    = (stall == 0);
        @(negedge clk);
        for (int c = 1; c <= len; c++) begin
            int s;
            int p;
            s = (c - 1) / 3;
            p = (c - 1) % 3;
            exp_v = {p == 0, (p != 0) && (s != 0), p == 2, 1'b0, 1'b1, 1'b0, 1'b0};
            got_v = {buf_rd_en, acc_sel, psum_we, res_valid, busy, cmd_ready, done_pulse};
            total++;
            if (got_v === exp_v) passed++;
            else $display("FAIL job_cycle_%0d: outputs=%b expected %b", c, got_v, exp_v);
            if (p == 0) begin
                rec_act[s] = act_addr;
                rec_wgt[s] = wgt_addr;
                total++;
                if (act_addr === ab + 10'(s) && wgt_addr === wb + 10'(s)) passed++;
                else $display("FAIL job_addr_step_%0d: act=%h wgt=%h expected %h %h",
                              s, act_addr, wgt_addr, ab + 10'(s), wb + 10'(s));
            end
            total++;
            if (arr_ctrl === mode) passed++;
            else $display("FAIL job_arr_ctrl_%0d: arr_ctrl=%b expected %b", c, arr_ctrl, mode);
            // A different command offered mid-job must be ignored.
            cmd_valid    = 1'b1;
            cmd_k        = 8'hFF ^ k;
            cmd_mode     = ~mode;
            cmd_act_base = ~ab;
            cmd_wgt_base = ~wb;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        for (int i = 0; i < stall; i++) begin
            got_v = {buf_rd_en, acc_sel, psum_we, res_valid, busy, cmd_ready, done_pulse};
            total++;
            if (got_v === 7'b0001100) passed++;
            else $display("FAIL job_stall_%0d: outputs=%b expected 0001100", i, got_v);
            @(negedge clk);
        end
        got_v = {buf_rd_en, acc_sel, psum_we, res_valid, busy, cmd_ready, done_pulse};
        total++;
        if (got_v === 7'b0001100) passed++;
        else $display("FAIL job_out: outputs=%b expected 0001100", got_v);
        res_ready = 1'b1;
        @(negedge clk);
        got_v = {buf_rd_en, acc_sel, psum_we, res_valid, busy, cmd_ready, done_pulse};
        total++;
        if (got_v === 7'b0000011) passed++;
        else $display("FAIL job_done: outputs=%b expected 0000011", got_v);
        total++;
        if (arr_ctrl === mode) passed++;
        else $display("FAIL job_idle_arr_ctrl: arr_ctrl=%b expected %b", arr_ctrl, mode);
`ifdef PERF_CNT_EN
        total++;
        if (perf_busy_cyc - busy0 === 32'(len + stall + 1)) passed++;
        else $display("FAIL perf_busy: delta=%0d expected %0d", perf_busy_cyc - busy0, len + stall + 1);
        total++;
        if (perf_stall_cyc - stall0 === 32'(stall)) passed++;
        else $display("FAIL perf_stall: delta=%0d expected %0d", perf_stall_cyc - stall0, stall);
`endif
        res_ready = 1'b0;
        @(negedge clk);
        total++;
        if (done_pulse === 1'b0) passed++;
        else $display("FAIL job_done_width: done_pulse=%b expected 0", done_pulse);
    endtask

    task automatic test_reset();
        reset        = 1'b0;
        cmd_valid    = 1'b1;
        cmd_k        = 8'd2;
        cmd_mode     = 2'b11;
        cmd_act_base = 10'h155;
        cmd_wgt_base = 10'h2AA;
        res_ready    = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({cmd_ready, buf_rd_en, act_addr, wgt_addr, arr_ctrl, acc_sel, psum_we,
             res_valid, busy, done_pulse} === 29'd0) passed++;
        else $display("FAIL reset_outputs: busy=%b cmd_ready=%b rd=%b expected all 0",
                      busy, cmd_ready, buf_rd_en);
        cmd_valid = 1'b0;
        res_ready = 1'b0;
        reset     = 1'b1;
        #1;
        total++;
        if (cmd_ready === 1'b0) passed++;
        else $display("FAIL reset_release_ready: cmd_ready=%b expected 0", cmd_ready);
        @(negedge clk);
        total++;
        if (cmd_ready === 1'b1 && busy === 1'b0) passed++;
        else $display("FAIL reset_ready_rise: cmd_ready=%b busy=%b expected 1 0", cmd_ready, busy);
    endtask

    task automatic test_basic();
        run_job(8'd3, 2'b01, 10'h010, 10'h200, 0);
        total++;
        if (rec_act[0] === 10'h010 && rec_act[1] === 10'h011 && rec_act[2] === 10'h012 &&
            rec_wgt[0] === 10'h200 && rec_wgt[1] === 10'h201 && rec_wgt[2] === 10'h202) passed++;
        else $display("FAIL basic_addrs: act=%h,%h,%h wgt=%h,%h,%h expected 010,011,012 200,201,202",
                      rec_act[0], rec_act[1], rec_act[2], rec_wgt[0], rec_wgt[1], rec_wgt[2]);
    endtask

    task automatic test_backpressure();
        run_job(8'd3, 2'b10, 10'h010, 10'h200, 5);
    endtask

    task automatic test_addr_wrap();
        run_job(8'd4, 2'b11, 10'h3FE, 10'h001, 0);
        total++;
        if (rec_act[0] === 10'h3FE && rec_act[1] === 10'h3FF &&
            rec_act[2] === 10'h000 && rec_act[3] === 10'h001) passed++;
        else $display("FAIL wrap_addrs: act=%h,%h,%h,%h expected 3fe,3ff,000,001",
                      rec_act[0], rec_act[1], rec_act[2], rec_act[3]);
    endtask

    task automatic test_k_zero();
        run_job(8'd0, 2'b01, 10'h123, 10'h321, 0);
    endtask

    task automatic test_k_max();
        run_job(8'd255, 2'b10, 10'h3F0, 10'h000, 1);
        total++;
        if (rec_act[254] === 10'h0EE && rec_wgt[254] === 10'h0FE) passed++;
        else $display("FAIL kmax_last_addr: act=%h wgt=%h expected 0ee 0fe", rec_act[254], rec_wgt[254]);
    endtask

    task automatic test_reset_mid_job();
        int waited;
        waited = 0;
        while (cmd_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        cmd_valid    = 1'b1;
        cmd_k        = 8'd3;
        cmd_mode     = 2'b11;
        cmd_act_base = 10'h100;
        cmd_wgt_base = 10'h050;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        total++;
        if (acc_sel === 1'b1 && psum_we === 1'b0 && busy === 1'b1) passed++;
        else $display("FAIL midjob_wait1: acc_sel=%b psum_we=%b busy=%b expected 1 0 1",
                      acc_sel, psum_we, busy);
        #2;
        reset = 1'b0;
        #1;
        total++;
        if ({cmd_ready, buf_rd_en, act_addr, wgt_addr, arr_ctrl, acc_sel, psum_we,
             res_valid, busy, done_pulse} === 29'd0) passed++;
        else $display("FAIL midjob_async_reset: busy=%b acc_sel=%b arr_ctrl=%b expected all 0",
                      busy, acc_sel, arr_ctrl);
`ifdef PERF_CNT_EN
        total++;
        if (perf_busy_cyc === 32'd0 && perf_stall_cyc === 32'd0) passed++;
        else $display("FAIL perf_reset: busy=%0d stall=%0d expected 0 0", perf_busy_cyc, perf_stall_cyc);
`endif
        repeat (2) @(negedge clk);
        reset = 1'b1;
        run_job(8'd1, 2'b10, 10'h005, 10'h006, 0);
    endtask

    initial begin
        reset        = 1'b0;
        cmd_valid    = 1'b0;
        cmd_k        = '0;
        cmd_mode     = '0;
        cmd_act_base = '0;
        cmd_wgt_base = '0;
        res_ready    = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_backpressure();
        test_addr_wrap();
        test_k_zero();
        test_k_max();
        test_reset_mid_job();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
